i2cs_reg_arbiter: RTL and testbench

Shares the single-port I2C-slave register file between the I2C peripheral interface and the APB host. Buffers I2C register writes, keeps a prefetched read byte ready for the I2C read path, and round-robins the register-file port between the I2C side and APB. Sits between `i2c_peripheral_interface` and the register file inside `apb_i2cs`.

---
 rtl/i2cs_reg_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_i2cs_reg_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cs_reg_arbiter.sv
// Register-file port arbiter between the I2C peripheral interface and the APB host.
// Optional macro I2CS_ARB_AUTOINC_EN: read-byte-complete advances the I2C read pointer.
module i2cs_reg_arbiter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] i2c_reg_addr_i,
  input  logic [7:0] i2c_reg_wdata_i,
  input  logic       i2c_reg_wrenable_i,
  input  logic       i2c_reg_rd_byte_complete_i,
  output logic [7:0] i2c_reg_rddata_o,
  output logic       i2c_wr_overflow_o,
  input  logic       apb_req_i,
  input  logic       apb_we_i,
  input  logic [7:0] apb_addr_i,
  input  logic [7:0] apb_wdata_i,
  output logic       apb_gnt_o,
  output logic       apb_rvalid_o,
  output logic [7:0] apb_rdata_o,
  output logic       rf_req_o,
  output logic       rf_we_o,
  output logic [7:0] rf_addr_o,
  output logic [7:0] rf_wdata_o,
  input  logic [7:0] rf_rdata_i
);

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_e;

  arb_state_e state_r;
  arb_state_e state_nxt_s;

  logic       wr_pend_r;
  logic [7:0] wr_addr_r;
  logic [7:0] wr_data_r;
  logic       overflow_r;
  logic [7:0] addr_q_r;
  logic [7:0] rd_ptr_r;
  logic       pf_pend_r;
  logic       last_i2c_r;
  logic       rd_apb_r;
  logic [7:0] rddata_r;
  logic [7:0] apb_rdata_r;
  logic       apb_rvalid_r;

  logic       i2c_class_s;
  logic       srv_wr_s;
  logic       srv_pf_s;
  logic       rf_req_s;
  logic       rf_we_s;
  logic [7:0] rf_addr_s;
  logic [7:0] rf_wdata_s;
  logic       gnt_s;
  logic       addr_chg_s;
  logic       wr_hit_s;

  assign i2c_class_s = wr_pend_r | pf_pend_r;
  assign addr_chg_s  = (i2c_reg_addr_i != addr_q_r);
  // An issued write to the prefetched address makes the buffered read byte stale.
  assign wr_hit_s    = rf_req_s & rf_we_s & (rf_addr_s == rd_ptr_r);

  // Arbitration and next-state decode; access is issued combinationally from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    srv_wr_s    = 1'b0;
    srv_pf_s    = 1'b0;
    rf_req_s    = 1'b0;
    rf_we_s     = 1'b0;
    rf_addr_s   = 8'h00;
    rf_wdata_s  = 8'h00;
    gnt_s       = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (i2c_class_s && (!apb_req_i || !last_i2c_r)) begin
          rf_req_s = 1'b1;
          if (wr_pend_r) begin
            rf_we_s    = 1'b1;
            rf_addr_s  = wr_addr_r;
            rf_wdata_s = wr_data_r;
            srv_wr_s   = 1'b1;
          end else begin
            rf_addr_s   = rd_ptr_r;
            srv_pf_s    = 1'b1;
            state_nxt_s = ARB_RD_WAIT;
          end
        end else if (apb_req_i) begin
          rf_req_s   = 1'b1;
          rf_we_s    = apb_we_i;
          rf_addr_s  = apb_addr_i;
          rf_wdata_s = apb_we_i ? apb_wdata_i : 8'h00;
          gnt_s      = 1'b1;
          if (!apb_we_i) begin
            state_nxt_s = ARB_RD_WAIT;
          end else begin
            state_nxt_s = ARB_IDLE;
          end
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_RD_WAIT: begin
        state_nxt_s = ARB_IDLE;
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  assign rf_req_o   = rst_ni & rf_req_s;
  assign rf_we_o    = rst_ni & rf_req_s & rf_we_s;
  assign apb_gnt_o  = rst_ni & gnt_s;
  assign rf_addr_o  = rf_req_o ? rf_addr_s  : 8'h00;
  assign rf_wdata_o = rf_req_o ? rf_wdata_s : 8'h00;

  // FSM state and round-robin history.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r    <= ARB_IDLE;
      last_i2c_r <= 1'b0;
      rd_apb_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (srv_wr_s || srv_pf_s) begin
        last_i2c_r <= 1'b1;
      end else if (gnt_s) begin
        last_i2c_r <= 1'b0;
      end else begin
        last_i2c_r <= last_i2c_r;
      end
      if (srv_pf_s) begin
        rd_apb_r <= 1'b0;
      end else if (gnt_s && !apb_we_i) begin
        rd_apb_r <= 1'b1;
      end else begin
        rd_apb_r <= rd_apb_r;
      end
    end
  end

  // Single-entry I2C write buffer; a write arriving while it is full is lost.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_pend_r  <= 1'b0;
      wr_addr_r  <= 8'h00;
      wr_data_r  <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      if (i2c_reg_wrenable_i && wr_pend_r) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
      if (i2c_reg_wrenable_i && !wr_pend_r) begin
        wr_pend_r <= 1'b1;
        wr_addr_r <= i2c_reg_addr_i;
        wr_data_r <= i2c_reg_wdata_i;
      end else if (srv_wr_s) begin
        wr_pend_r <= 1'b0;
      end else begin
        wr_pend_r <= wr_pend_r;
      end
    end
  end

  // Read pointer tracking and prefetch request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q_r  <= 8'h00;
      rd_ptr_r  <= 8'h00;
      pf_pend_r <= 1'b0;
    end else begin
      addr_q_r <= i2c_reg_addr_i;
      if (addr_chg_s) begin
        rd_ptr_r <= i2c_reg_addr_i;
      end else if (i2c_reg_rd_byte_complete_i) begin
`ifdef I2CS_ARB_AUTOINC_EN
        rd_ptr_r <= rd_ptr_r + 8'd1;
`else
        rd_ptr_r <= rd_ptr_r;
`endif
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      // New triggers take priority over retiring the prefetch issued this cycle.
      if (addr_chg_s || i2c_reg_rd_byte_complete_i || wr_hit_s) begin
        pf_pend_r <= 1'b1;
      end else if (srv_pf_s) begin
        pf_pend_r <= 1'b0;
      end else begin
        pf_pend_r <= pf_pend_r;
      end
    end
  end

  // Read data capture while the single outstanding read completes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rddata_r     <= 8'h00;
      apb_rdata_r  <= 8'h00;
      apb_rvalid_r <= 1'b0;
    end else begin
      apb_rvalid_r <= 1'b0;
      if (state_r == ARB_RD_WAIT) begin
        if (rd_apb_r) begin
          apb_rdata_r  <= rf_rdata_i;
          apb_rvalid_r <= 1'b1;
        end else begin
          rddata_r <= rf_rdata_i;
        end
      end else begin
        rddata_r    <= rddata_r;
        apb_rdata_r <= apb_rdata_r;
      end
    end
  end

  assign i2c_reg_rddata_o  = rddata_r;
  assign i2c_wr_overflow_o = overflow_r;
  assign apb_rdata_o       = apb_rdata_r;
  assign apb_rvalid_o      = apb_rvalid_r;

endmodule

// File: tb/tb_i2cs_reg_arbiter.sv
// Self-checking bench for i2cs_reg_arbiter: directed scenarios plus a randomized
// phase scored against a golden register image kept in the bench.
module tb_i2cs_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i2c_addr, i2c_wdata;
  logic       i2c_wren, i2c_done;
  logic [7:0] i2c_rddata;
  logic       i2c_ovf;
  logic       apb_req, apb_we;
  logic [7:0] apb_addr, apb_wdata;
  logic       apb_gnt, apb_rvalid;
  logic [7:0] apb_rdata;
  logic       rf_req, rf_we;
  logic [7:0] rf_addr, rf_wdata;
  logic [7:0] rf_rdata;

  logic       init_mem;
  logic [7:0] mem    [256];
  logic [7:0] golden [256];

  int n_assert = 0;
  int n_fail   = 0;

  i2cs_reg_arbiter dut (
    .clk_i                      (clk),
    .rst_ni                     (rst_n),
    .i2c_reg_addr_i             (i2c_addr),
    .i2c_reg_wdata_i            (i2c_wdata),
    .i2c_reg_wrenable_i         (i2c_wren),
    .i2c_reg_rd_byte_complete_i (i2c_done),
    .i2c_reg_rddata_o           (i2c_rddata),
    .i2c_wr_overflow_o          (i2c_ovf),
    .apb_req_i                  (apb_req),
    .apb_we_i                   (apb_we),
    .apb_addr_i                 (apb_addr),
    .apb_wdata_i                (apb_wdata),
    .apb_gnt_o                  (apb_gnt),
    .apb_rvalid_o               (apb_rvalid),
    .apb_rdata_o                (apb_rdata),
    .rf_req_o                   (rf_req),
    .rf_we_o                    (rf_we),
    .rf_addr_o                  (rf_addr),
    .rf_wdata_o                 (rf_wdata),
    .rf_rdata_i                 (rf_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous register file: write at the edge, read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 85);
    end else if (rf_req) begin
      if (rf_we) mem[rf_addr] <= rf_wdata;
      else       rf_rdata     <= mem[rf_addr];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rd);
    int n;
    n = 0;
    apb_req = 1'b1; apb_we = we; apb_addr = a; apb_wdata = d;
    #1;
    while (!apb_gnt && n < 20) begin cyc(); #1; n++; end
    chk("apb_gnt_seen", {31'd0, apb_gnt}, 32'd1);
    cyc();
    apb_req = 1'b0;
    rd = 8'h00;
    if (!we) begin
      n = 0;
      #1;
      while (!apb_rvalid && n < 5) begin cyc(); #1; n++; end
      chk("apb_rvalid_seen", {31'd0, apb_rvalid}, 32'd1);
      rd = apb_rdata;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_req"},   {31'd0, rf_req},     32'd0);
    chk({tag, "_rf_we"},    {31'd0, rf_we},      32'd0);
    chk({tag, "_gnt"},      {31'd0, apb_gnt},    32'd0);
    chk({tag, "_rvalid"},   {31'd0, apb_rvalid}, 32'd0);
    chk({tag, "_ovf"},      {31'd0, i2c_ovf},    32'd0);
    chk({tag, "_rddata"},   {24'd0, i2c_rddata}, 32'd0);
    chk({tag, "_apbrdata"}, {24'd0, apb_rdata},  32'd0);
    chk({tag, "_rf_addr"},  {24'd0, rf_addr},    32'd0);
    chk({tag, "_rf_wdata"}, {24'd0, rf_wdata},   32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, a, d, exp_ptr, wdat;
    logic       prev_apb, have_prev;
    int         n, grants, op;

    for (int i = 0; i < 256; i++) golden[i] = 8'(i * 37 + 85);
    rst_n = 1'b0; init_mem = 1'b1;
    i2c_addr = 8'h00; i2c_wdata = 8'h00; i2c_wren = 1'b0; i2c_done = 1'b0;
    apb_req = 1'b0; apb_we = 1'b0; apb_addr = 8'h00; apb_wdata = 8'h00;

    // Reset: outputs quiet even with an APB request present.
    cyc(); init_mem = 1'b0;
    cyc();
    apb_req = 1'b1; apb_addr = 8'h44; apb_we = 1'b1; apb_wdata = 8'h99;
    #1;
    chk_reset_outputs("reset");
    apb_req = 1'b0;

    // Address change to 0x10 triggers one prefetch strobe and returns 0xA5.
    cyc(); rst_n = 1'b1;
    cyc(); i2c_addr = 8'h10; #1;
    chk("pf_not_yet", {31'd0, rf_req}, 32'd0);
    cyc(); #1;
    chk("pf_strobe", {31'd0, rf_req}, 32'd1);
    chk("pf_is_read", {31'd0, rf_we}, 32'd0);
    chk("pf_addr", {24'd0, rf_addr}, 32'h10);
    cyc(); #1;
    chk("pf_wait_quiet", {31'd0, rf_req}, 32'd0);
    cyc(); #1;
    chk("pf_data_a5", {24'd0, i2c_rddata}, 32'hA5);

    // Read pointer at 0xFF and a byte-complete pulse.
    i2c_addr = 8'hFF;
    repeat (4) cyc();
    #1;
    chk("pf_ff", {24'd0, i2c_rddata}, {24'd0, golden[8'hFF]});
`ifdef I2CS_ARB_AUTOINC_EN
    exp_ptr = 8'h00;
`else
    exp_ptr = 8'hFF;
`endif
    cyc(); i2c_done = 1'b1;
    cyc(); i2c_done = 1'b0; #1;
    chk("done_strobe", {31'd0, rf_req}, 32'd1);
    chk("done_addr", {24'd0, rf_addr}, {24'd0, exp_ptr});
    cyc(); cyc(); #1;
    chk("done_data", {24'd0, i2c_rddata}, {24'd0, golden[exp_ptr]});

    // Fresh reset, then I2C write and APB read contend: I2C wins the first tie.
    cyc(); rst_n = 1'b0; i2c_addr = 8'h00;
    cyc(); cyc(); rst_n = 1'b1;
    cyc(); i2c_addr = 8'h20; i2c_wdata = 8'h77; i2c_wren = 1'b1;
    cyc(); i2c_wren = 1'b0; apb_req = 1'b1; apb_we = 1'b0; apb_addr = 8'h30; #1;
    chk("tie_i2c_req", {31'd0, rf_req}, 32'd1);
    chk("tie_i2c_we", {31'd0, rf_we}, 32'd1);
    chk("tie_i2c_nogrant", {31'd0, apb_gnt}, 32'd0);
    chk("tie_i2c_addr", {24'd0, rf_addr}, 32'h20);
    chk("tie_i2c_wdata", {24'd0, rf_wdata}, 32'h77);
    golden[8'h20] = 8'h77;
    cyc(); #1;
    chk("tie_apb_gnt", {31'd0, apb_gnt}, 32'd1);
    chk("tie_apb_addr", {24'd0, rf_addr}, 32'h30);
    chk("tie_apb_rd", {31'd0, rf_we}, 32'd0);
    cyc(); apb_req = 1'b0; #1;
    chk("tie_rdwait_quiet", {31'd0, rf_req}, 32'd0);
    cyc(); #1;
    chk("tie_rvalid", {31'd0, apb_rvalid}, 32'd1);
    chk("tie_rdata", {24'd0, apb_rdata}, {24'd0, golden[8'h30]});
    repeat (4) cyc();

    // Continuous mutual requests: grants alternate between the classes.
    have_prev = 1'b0; prev_apb = 1'b0; grants = 0; wdat = 8'h01;
    for (int k = 0; k < 16; k++) begin
      cyc();
      i2c_addr = (k % 2 == 0) ? 8'h40 : 8'h41;
      apb_req = 1'b1; apb_we = 1'b1; apb_addr = 8'h50; apb_wdata = wdat;
      #1;
      if (rf_req) begin
        grants++;
        if (have_prev) chk("alternate", {31'd0, apb_gnt}, {31'd0, ~prev_apb});
        prev_apb = apb_gnt; have_prev = 1'b1;
        if (apb_gnt) begin
          golden[8'h50] = wdat;
          wdat = wdat + 8'd1;
        end
      end
    end
    cyc(); apb_req = 1'b0;
    chk("alt_grant_count", {31'd0, grants >= 8}, 32'd1);
    repeat (6) cyc();

    // APB write to the prefetched address refreshes the I2C read byte.
    i2c_addr = 8'h60;
    repeat (5) cyc();
    #1;
    chk("coh_before", {24'd0, i2c_rddata}, {24'd0, golden[8'h60]});
    apb_xfer(1'b1, 8'h60, 8'h3C, rd);
    golden[8'h60] = 8'h3C;
    repeat (4) cyc();
    #1;
    chk("coh_after", {24'd0, i2c_rddata}, 32'h3C);

    // Overflow: second I2C write lands while the first is still buffered.
    repeat (3) cyc();
    apb_req = 1'b1; apb_we = 1'b0; apb_addr = 8'h05; #1;
    chk("ovf_apb_gnt", {31'd0, apb_gnt}, 32'd1);
    cyc(); apb_req = 1'b0; i2c_addr = 8'h72; i2c_wdata = 8'h11; i2c_wren = 1'b1;
    cyc(); i2c_addr = 8'h73; i2c_wdata = 8'h22; #1;
    chk("ovf_first_issued", {31'd0, rf_req & rf_we}, 32'd1);
    chk("ovf_first_addr", {24'd0, rf_addr}, 32'h72);
    chk("ovf_first_data", {24'd0, rf_wdata}, 32'h11);
    chk("ovf_apb_rvalid", {31'd0, apb_rvalid}, 32'd1);
    chk("ovf_apb_rdata", {24'd0, apb_rdata}, {24'd0, golden[8'h05]});
    golden[8'h72] = 8'h11;
    cyc(); i2c_wren = 1'b0; #1;
    chk("ovf_flag", {31'd0, i2c_ovf}, 32'd1);
    repeat (5) cyc();
    #1;
    chk("ovf_sticky", {31'd0, i2c_ovf}, 32'd1);
    chk("ovf_mem_kept", {24'd0, mem[8'h72]}, 32'h11);
    chk("ovf_mem_dropped", {24'd0, mem[8'h73]}, {24'd0, golden[8'h73]});

    // Reset while an APB read is outstanding: the read is discarded.
    apb_req = 1'b1; apb_we = 1'b0; apb_addr = 8'h33; n = 0; #1;
    while (!apb_gnt && n < 20) begin cyc(); #1; n++; end
    chk("rst_rd_gnt", {31'd0, apb_gnt}, 32'd1);
    cyc(); apb_req = 1'b0; rst_n = 1'b0; i2c_addr = 8'h00;
    cyc(); #1;
    chk_reset_outputs("rst_mid");
    cyc(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("rst_no_rvalid", {31'd0, apb_rvalid}, 32'd0);
    end

    // Randomized phase: APB on 0x00-0x7F, I2C writes on 0x80-0xFF, I2C reads anywhere.
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          a = 8'($urandom_range(0, 127)); d = 8'($urandom);
          apb_xfer(1'b1, a, d, rd);
          golden[a] = d;
        end
        1: begin
          a = 8'($urandom_range(0, 127));
          apb_xfer(1'b0, a, 8'h00, rd);
          chk("rnd_apb_rd", {24'd0, rd}, {24'd0, golden[a]});
        end
        2: begin
          a = 8'($urandom_range(128, 255)); d = 8'($urandom);
          cyc(); i2c_addr = a; i2c_wdata = d; i2c_wren = 1'b1;
          cyc(); i2c_wren = 1'b0;
          repeat (4) cyc();
          golden[a] = d;
          chk("rnd_i2c_wr", {24'd0, mem[a]}, {24'd0, d});
        end
        default: begin
          a = 8'($urandom_range(0, 255));
          if (a == i2c_addr) a = a ^ 8'h01;
          cyc(); i2c_addr = a;
          repeat (4) cyc();
          #1;
          chk("rnd_i2c_rd", {24'd0, i2c_rddata}, {24'd0, golden[a]});
        end
      endcase
    end
    repeat (5) cyc();
    #1;
    chk("rnd_final_rd", {24'd0, i2c_rddata}, {24'd0, golden[i2c_addr]});
    chk("rnd_no_ovf", {31'd0, i2c_ovf}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
